bram_tdp_port_arbiter: RTL and testbench
========================================

// Module: bram_tdp_port_arbiter
// PURPOSE
// Shares one port (A1/A2/B1/B2) of a TDP36K block RAM, used in 18-bit mode, between NUM_REQ requesters.
// Arbitration is round-robin with a valid/ready request handshake.
// Pin controls are registered, and read responses come back tagged with the requester ID.
// An optional post-reset clear engine writes CLEAR_VAL to every word before any requester is granted.
// Sits between user logic and the RAM port pins (ADDR/WDATA/RDATA/REN/WEN/BE).
// PARAMETERS
// NUM_REQ         4        number of requesters, 2..8
// AW              10       word address width, 18-bit words, 1..10
// CLEAR_ON_RESET  1        1: run clear sweep after reset; 0: go to RUN immediately
// CLEAR_VAL       18'h0    data written by the clear sweep
// PORTS
// CLK_i            in   1             port clock; all state on rising edge
// RST_i            in   1             asynchronous, active-high reset
// req_valid_i      in   NUM_REQ       per-requester request valid
// req_ready_o      out  NUM_REQ       one-hot grant; transfer when valid & ready
// req_we_i         in   NUM_REQ       1 = write, 0 = read
// req_addr_i       in   NUM_REQ*AW    flat; requester i at [i*AW +: AW]
// req_wdata_i      in   NUM_REQ*18    flat write data
// req_be_i         in   NUM_REQ*2     flat byte enables
// rsp_valid_o      out  1             read data valid, single-cycle pulse, no backpressure
// rsp_id_o         out  $clog2(NUM_REQ)  requester index of the response
// rsp_data_o       out  18            read data
// init_done_o      out  1             high once clear is complete (or immediately if CLEAR_ON_RESET=0)
// ADDR_o           out  14            RAM address = {zero-pad, word_addr, 4'b0000}
// WDATA_o          out  18            RAM write data
// REN_o            out  1             RAM read enable
// WEN_o            out  1             RAM write enable
// BE_o             out  2             RAM byte enables
// RDATA_i          in   18            RAM read data, valid 1 cycle after REN_o
// BEHAVIOUR
// - Reset (asynchronous, any time): state=CLEAR (or RUN if CLEAR_ON_RESET=0); clr_cnt=0; rr_ptr=0.
//   req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, init_done_o=0, ADDR_o=0, WDATA_o=0, REN_o=WEN_o=0, BE_o=0.
//   In-flight reads are discarded; the clear sweep restarts from address 0.
// - State CLEAR: req_ready_o=0; requesters must hold their requests.
//   Each cycle: WEN_o=1, BE_o=2'b11, REN_o=0, WDATA_o=CLEAR_VAL, ADDR_o={clr_cnt,4'b0}; clr_cnt++.
//   After the write to word 2^AW-1, go to RUN; init_done_o=1 in the cycle after that last write.
// - State RUN (terminal until reset): init_done_o=1.
//   Grant (combinational): scan from rr_ptr upward, modulo NUM_REQ; the first valid requester i gets
//   req_ready_o[i]=1. At most one bit is set. req_ready_o=0 if no requester is valid.
// - On accept of i: rr_ptr <= (i+1)%NUM_REQ. With no accept, rr_ptr holds.
// - Pin drive, registered, 1 cycle after accept:
//   - Write: WEN_o=1, REN_o=0, BE_o=be_i, WDATA_o=wdata_i, ADDR_o={addr_i,4'b0}.
//   - Read: REN_o=1, WEN_o=0, BE_o=0, ADDR_o from addr_i; WDATA_o holds its previous value.
//   - Idle cycle: REN_o=WEN_o=0, BE_o=0; ADDR_o and WDATA_o hold.
// - Read latency: accept at T -> REN_o at T+1 -> rsp_valid_o=1 at T+2.
//   rsp_data_o=RDATA_i in that cycle; rsp_id_o=i, carried by a 2-stage tag pipe.
//   Full throughput: one request accepted per cycle; back-to-back read responses every cycle.
// - Read after write to the same address from consecutive grants: returns the new data
//   (write pin-cycle precedes read pin-cycle).
// - Address bits above AW+4 are driven 0. Unused high bits of the flat buses are ignored.
// TESTING
// - AW=4, CLEAR_ON_RESET=1, CLEAR_VAL=18'h15555, release RST_i ->
//   16 WEN_o cycles, ADDR_o=0,16,...,240, WDATA_o=18'h15555; init_done_o rises the next cycle.
// - Requester 2: write addr 5, data 18'h2A5A5, be 2'b11; then read addr 5 ->
//   rsp_valid_o 2 cycles after read accept, rsp_id_o=2, rsp_data_o=18'h2A5A5.
// - All 4 requesters valid continuously for 12 cycles ->
//   grants 0,1,2,3 repeating, each exactly 3 times, never two bits at once.
// - Requester 1 valid during CLEAR -> req_ready_o[1]=0 throughout;
//   granted in the first RUN cycle (rr_ptr=0, others idle).
// - Accept read at T; assert RST_i at T+1 ->
//   no rsp_valid_o pulse; all outputs at reset values; clear restarts at ADDR_o=0.
// - Write with be=2'b01 -> BE_o=2'b01 and WEN_o=1 exactly one cycle after accept; REN_o=0.

Source files
------------

// File: rtl/bram_tdp_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_tdp_port_arbiter
// Purpose  : Round-robin arbiter that shares one TDP36K port (18-bit mode)
//            between NUM_REQ requesters. It registers the RAM pin controls,
//            tags read responses with the requester ID, and can optionally
//            sweep CLEAR_VAL into every word after reset.
// Revision : 1.0 - initial release
// ============================================================================
module bram_tdp_port_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          AW             = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [17:0] CLEAR_VAL      = 18'h0
) (
  input  logic                       CLK_i,
  input  logic                       RST_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_we_i,
  input  logic [NUM_REQ*AW-1:0]      req_addr_i,
  input  logic [NUM_REQ*18-1:0]      req_wdata_i,
  input  logic [NUM_REQ*2-1:0]       req_be_i,
  output logic                       rsp_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [17:0]                rsp_data_o,
  output logic                       init_done_o,
  output logic [13:0]                ADDR_o,
  output logic [17:0]                WDATA_o,
  output logic                       REN_o,
  output logic                       WEN_o,
  output logic [1:0]                 BE_o,
  input  logic [17:0]                RDATA_i
);

  localparam int             IDW         = $clog2(NUM_REQ);
  localparam logic [0:0]     S_CLEAR     = 1'b0;
  localparam logic [0:0]     S_RUN       = 1'b1;
  localparam logic [0:0]     c_RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
  localparam logic [AW-1:0]  c_CLR_LAST  = '1;
  localparam logic [IDW:0]   c_NREQ      = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] c_LAST_ID   = IDW'(NUM_REQ - 1);

  // Word address placed at bit 4 of the 14-bit RAM address, upper bits zero.
  function automatic logic [13:0] f_word_addr(input logic [AW-1:0] w);
    logic [13:0] a;
    a = '0;
    a[AW+3:4] = w;
    return a;
  endfunction

  logic [0:0]          state_q, state_d;
  logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                init_done_q;
  logic [13:0]         addr_q, addr_d;
  logic [17:0]         wdata_q, wdata_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic [1:0]          be_q, be_d;
  logic                rd_v1_q, rd_v1_d;
  logic [IDW-1:0]      rd_id1_q;
  logic                rsp_valid_q;
  logic [IDW-1:0]      rsp_id_q;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_shift;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [IDW:0]         w_sum;
  logic [IDW-1:0]       w_gnt_id;
  logic [NUM_REQ-1:0]   w_grant;
  logic [AW-1:0]        w_sel_addr;
  logic [17:0]          w_sel_wdata;
  logic [1:0]           w_sel_be;
  logic                 w_sel_we;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr, then
  // pick the first set bit and map it back to an absolute index.
  assign w_dbl   = {req_valid_i, req_valid_i};
  assign w_shift = w_dbl >> rr_ptr_q;
  assign w_rot   = w_shift[NUM_REQ-1:0];

  // Round-robin priority scan.
  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      end
    end
    if (w_sum >= c_NREQ) w_sum = w_sum - c_NREQ;
    w_gnt_id = w_sum[IDW-1:0];
    w_grant  = '0;
    if (w_found) w_grant[w_gnt_id] = 1'b1;
  end

  assign w_sel_addr  = req_addr_i[int'(w_gnt_id)*AW +: AW];
  assign w_sel_wdata = req_wdata_i[int'(w_gnt_id)*18 +: 18];
  assign w_sel_be    = req_be_i[int'(w_gnt_id)*2 +: 2];
  assign w_sel_we    = req_we_i[w_gnt_id];

  // State register.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) state_q <= c_RST_STATE;
    else       state_q <= state_d;
  end

  // Next state: leave CLEAR once the last word has been issued.
  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_cnt_q == c_CLR_LAST) state_d = S_RUN;
  end

  // Outputs and datapath next values: clear sweep or granted request.
  always_comb begin
    req_ready_o = '0;
    clr_cnt_d   = clr_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ren_d       = 1'b0;
    wen_d       = 1'b0;
    be_d        = 2'b00;
    rd_v1_d     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wen_d     = 1'b1;
        be_d      = 2'b11;
        wdata_d   = CLEAR_VAL;
        addr_d    = f_word_addr(clr_cnt_q);
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
      S_RUN: begin
        req_ready_o = w_grant;
        if (w_found) begin
          rr_ptr_d = (w_gnt_id == c_LAST_ID) ? '0 : w_gnt_id + 1'b1;
          addr_d   = f_word_addr(w_sel_addr);
          if (w_sel_we) begin
            wen_d   = 1'b1;
            be_d    = w_sel_be;
            wdata_d = w_sel_wdata;
          end else begin
            ren_d   = 1'b1;
            rd_v1_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Pin registers, clear counter, round-robin pointer and response tag pipe.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      clr_cnt_q   <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      be_q        <= 2'b00;
      rd_v1_q     <= 1'b0;
      rd_id1_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= (state_q == S_RUN);
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ren_q       <= ren_d;
      wen_q       <= wen_d;
      be_q        <= be_d;
      rd_v1_q     <= rd_v1_d;
      rd_id1_q    <= w_gnt_id;
      rsp_valid_q <= rd_v1_q;
      rsp_id_q    <= rd_id1_q;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = RDATA_i;
  assign init_done_o = init_done_q;
  assign ADDR_o      = addr_q;
  assign WDATA_o     = wdata_q;
  assign REN_o       = ren_q;
  assign WEN_o       = wen_q;
  assign BE_o        = be_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_tdp_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_tdp_port_arbiter
// Purpose  : Self-checking bench for bram_tdp_port_arbiter with a 1-cycle
//            RAM model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_tdp_port_arbiter;

  localparam int          NUM_REQ = 4;
  localparam int          AW      = 4;
  localparam logic [17:0] CV      = 18'h15555;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_we = '0;
  logic [NUM_REQ*AW-1:0]   req_addr = '0;
  logic [NUM_REQ*18-1:0]   req_wdata = '0;
  logic [NUM_REQ*2-1:0]    req_be = '0;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [17:0]             rsp_data;
  logic                    init_done;
  logic [13:0]             addr_pin;
  logic [17:0]             wdata_pin;
  logic                    ren_pin, wen_pin;
  logic [1:0]              be_pin;
  logic [17:0]             ram_rdata = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int model_rr = 0;

  typedef struct packed { logic [1:0] id; logic [17:0] data; } rsp_t;
  rsp_t        sb_q[$];
  rsp_t        sb_e;
  logic [17:0] shadow [16];
  logic [17:0] ram    [16];

  bram_tdp_port_arbiter #(
    .NUM_REQ(NUM_REQ), .AW(AW), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CV)
  ) dut (
    .CLK_i(clk), .RST_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .init_done_o(init_done), .ADDR_o(addr_pin), .WDATA_o(wdata_pin),
    .REN_o(ren_pin), .WEN_o(wen_pin), .BE_o(be_pin), .RDATA_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM port model: byte-enabled write, read data one cycle after REN.
  always @(posedge clk) begin
    if (wen_pin) begin
      if (be_pin[0]) ram[addr_pin[7:4]][8:0]  <= wdata_pin[8:0];
      if (be_pin[1]) ram[addr_pin[7:4]][17:9] <= wdata_pin[17:9];
    end
    if (ren_pin) ram_rdata <= ram[addr_pin[7:4]];
  end

  // Scoreboard: reads push expected data at accept, responses pop and compare.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      model_rr = 0;
      for (int i = 0; i < 16; i++) shadow[i] = CV;
    end else begin
      if (rsp_valid) begin
        chk_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got id %0d data %h, required no response", rsp_id, rsp_data);
        end else begin
          sb_e = sb_q.pop_front();
          if ({rsp_id, rsp_data} !== {sb_e.id, sb_e.data})
            $display("FAIL rsp_sb: got id %0d data %h, required id %0d data %h",
                     rsp_id, rsp_data, sb_e.id, sb_e.data);
          else pass_cnt++;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          model_rr = (i + 1) % NUM_REQ;
          if (req_we[i]) begin
            if (req_be[i*2])   shadow[req_addr[i*AW +: AW]][8:0]  = req_wdata[i*18 +: 9];
            if (req_be[i*2+1]) shadow[req_addr[i*AW +: AW]][17:9] = req_wdata[i*18+9 +: 9];
          end else begin
            sb_q.push_back({2'(i), shadow[req_addr[i*AW +: AW]]});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [17:0] d, input logic [1:0] be);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*18 +: 18] = d;
    req_be[i*2 +: 2] = be;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0) $display("FAIL rst_ready: got %b required 0", req_ready); else pass_cnt++;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_id !== 2'd0) $display("FAIL rst_rsp_id: got %0d required 0", rsp_id); else pass_cnt++;
    chk_cnt++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b required 0", init_done); else pass_cnt++;
    chk_cnt++; if (addr_pin !== 14'd0) $display("FAIL rst_addr: got %h required 0", addr_pin); else pass_cnt++;
    chk_cnt++; if (wdata_pin !== 18'd0) $display("FAIL rst_wdata: got %h required 0", wdata_pin); else pass_cnt++;
    chk_cnt++; if ({ren_pin, wen_pin, be_pin} !== 4'b0) $display("FAIL rst_ctrl: got %b required 0000", {ren_pin, wen_pin, be_pin}); else pass_cnt++;
  endtask

  // Requester 1 reads word 3 while the clear sweep runs.
  task automatic test_clear_sweep();
    int  n = 0;
    bit  drop = 1'b0;
    bit  done = 1'b0;
    set_req(1, 1'b0, 4'd3, 18'h0, 2'b00);
    step();
    rst = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) step();
      if (drop) req_valid[1] = 1'b0;
      @(negedge clk);
      if (n == 16) begin
        chk_cnt++; if (init_done !== 1'b1) $display("FAIL clr_init_done: got %b required 1", init_done); else pass_cnt++;
        chk_cnt++; if ({ren_pin, wen_pin} !== 2'b10) $display("FAIL clr_first_read: got ren/wen %b required 10", {ren_pin, wen_pin}); else pass_cnt++;
        done = 1'b1;
      end else if (wen_pin) begin
        chk_cnt++;
        if ({addr_pin, wdata_pin, be_pin, ren_pin, init_done} !== {14'(n*16), CV, 2'b11, 1'b0, 1'b0})
          $display("FAIL clr_write%0d: got addr %h data %h be %b ren %b done %b, required addr %h data %h be 11 ren 0 done 0",
                   n, addr_pin, wdata_pin, be_pin, ren_pin, init_done, 14'(n*16), CV);
        else pass_cnt++;
        chk_cnt++;
        if (req_ready !== ((n == 15) ? 4'b0010 : 4'b0000))
          $display("FAIL clr_ready%0d: got %b required %b", n, req_ready, (n == 15) ? 4'b0010 : 4'b0000);
        else pass_cnt++;
        if (n == 15) drop = 1'b1;
        n++;
      end else begin
        chk_cnt++; if (n != 0) $display("FAIL clr_gap: got WEN 0 after %0d writes, required 1", n); else pass_cnt++;
        chk_cnt++; if (req_ready !== 4'b0) $display("FAIL clr_pre_ready: got %b required 0", req_ready); else pass_cnt++;
      end
    end
    if (!done) begin chk_cnt++; $display("FAIL clr_timeout: got %0d writes, required 16 then init_done", n); end
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic test_write_read();
    set_req(2, 1'b1, 4'd5, 18'h2A5A5, 2'b11);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL wr_grant: got %b required 0100", req_ready); else pass_cnt++;
    step();
    req_we[2] = 1'b0;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0100) $display("FAIL rd_grant: got %b required 0100", req_ready); else pass_cnt++;
    chk_cnt++;
    if ({wen_pin, ren_pin, be_pin, addr_pin, wdata_pin} !== {1'b1, 1'b0, 2'b11, 14'd80, 18'h2A5A5})
      $display("FAIL wr_pins: got wen %b ren %b be %b addr %h data %h, required 1 0 11 050 2a5a5", wen_pin, ren_pin, be_pin, addr_pin, wdata_pin);
    else pass_cnt++;
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({wen_pin, ren_pin, be_pin, addr_pin, wdata_pin, rsp_valid} !== {1'b0, 1'b1, 2'b00, 14'd80, 18'h2A5A5, 1'b0})
      $display("FAIL rd_pins: got wen %b ren %b be %b addr %h data %h rspv %b, required 0 1 00 050 2a5a5 0", wen_pin, ren_pin, be_pin, addr_pin, wdata_pin, rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 18'h2A5A5})
      $display("FAIL rd_rsp: got v %b id %0d data %h, required 1 2 2a5a5", rsp_valid, rsp_id, rsp_data);
    else pass_cnt++;
    repeat (3) step();
  endtask

  task automatic test_round_robin();
    int exp_id;
    int cnt [NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0;
      set_req(i, 1'b0, 4'(i + 8), 18'h0, 2'b00);
    end
    exp_id = model_rr;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 4'(1 << exp_id)) $display("FAIL rr_grant%0d: got %b required %b", k, req_ready, 4'(1 << exp_id));
      else pass_cnt++;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) cnt[i]++;
      exp_id = (exp_id + 1) % NUM_REQ;
      step();
      if (k == 11) req_valid = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      chk_cnt++; if (cnt[i] != 3) $display("FAIL rr_count%0d: got %0d grants required 3", i, cnt[i]); else pass_cnt++;
    end
    repeat (4) step();
  endtask

  task automatic test_byte_enable();
    set_req(0, 1'b1, 4'd7, 18'h3FFFF, 2'b01);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b0001) $display("FAIL be_grant: got %b required 0001", req_ready); else pass_cnt++;
    step();
    req_we[0] = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({be_pin, wen_pin, ren_pin, addr_pin, wdata_pin} !== {2'b01, 1'b1, 1'b0, 14'd112, 18'h3FFFF})
      $display("FAIL be_pins: got be %b wen %b ren %b addr %h data %h, required 01 1 0 070 3ffff", be_pin, wen_pin, ren_pin, addr_pin, wdata_pin);
    else pass_cnt++;
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({wen_pin, ren_pin, be_pin} !== 4'b0100) $display("FAIL be_one_cycle: got wen %b ren %b be %b, required 0 1 00", wen_pin, ren_pin, be_pin);
    else pass_cnt++;
    repeat (4) step();
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    set_req(3, 1'b0, 4'd2, 18'h0, 2'b00);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 4'b1000) $display("FAIL inf_grant: got %b required 1000", req_ready); else pass_cnt++;
    step();
    req_valid[3] = 1'b0;
    @(negedge clk);
    chk_cnt++; if (ren_pin !== 1'b1) $display("FAIL inf_ren: got %b required 1", ren_pin); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({req_ready, rsp_valid, rsp_id, init_done, addr_pin, wdata_pin, ren_pin, wen_pin, be_pin} !== '0)
      $display("FAIL inf_rst_outputs: got ready %b v %b id %0d done %b addr %h data %h ren %b wen %b be %b, required all 0",
               req_ready, rsp_valid, rsp_id, init_done, addr_pin, wdata_pin, ren_pin, wen_pin, be_pin);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL inf_no_rsp%0d: got %b required 0", k, rsp_valid); else pass_cnt++;
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (wen_pin) begin
        seen = 1'b1;
        chk_cnt++; if (addr_pin !== 14'd0) $display("FAIL inf_clr_restart: got addr %h required 0", addr_pin); else pass_cnt++;
      end
    end
    if (!seen) begin chk_cnt++; $display("FAIL inf_clr_timeout: got no WEN, required clear restart"); end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (init_done) seen = 1'b1;
    end
    chk_cnt++; if (!seen) $display("FAIL inf_init_timeout: got init_done 0, required 1"); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = CV;
    test_reset();
    test_clear_sweep();
    test_write_read();
    test_round_robin();
    test_byte_enable();
    test_reset_inflight();
    repeat (4) step();
    chk_cnt++; if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d outstanding reads required 0", sb_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
